// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding the architectural HI/LO pair.
// mult/div results are computed at the start edge, parked in a pending
// register, and committed to HI/LO when the busy countdown expires, so the
// visible latency is set by MULT_CYCLES / DIV_CYCLES rather than by the
// arithmetic itself.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW0  = $clog2(MAXC + 1);
    localparam int CW   = (CW0 < 4) ? 4 : CW0;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_pend;
    logic          r_pend_ok;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_done;
    logic          w_free;
    logic          w_accept;
    logic          w_idle_start;
    logic          w_is_div;
    logic          w_dz;
    logic [63:0]   w_res;
    logic [63:0]   w_mul_s;
    logic [63:0]   w_mul_u;
    logic [31:0]   w_a_abs;
    logic [31:0]   w_b_abs;
    logic [31:0]   w_div_b;
    logic [31:0]   w_q_u;
    logic [31:0]   w_r_u;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic          w_sdiv;

    // Handshake decode: the terminal RUN edge also counts as free so a new
    // mult/div can issue back-to-back with the commit.
    assign w_done       = (r_state == S_RUN) && (r_cnt == CW'(1));
    assign w_free       = (r_state == S_IDLE) || w_done;
    assign w_accept     = w_free && start && !md_op[2];
    assign w_idle_start = (r_state == S_IDLE) && start;
    assign w_is_div     = md_op[1];
    assign w_dz         = (b == 32'd0);

    // Arithmetic: both products plus a magnitude-based divider; dividing the
    // magnitudes keeps 0x80000000 / -1 well defined (quotient wraps to
    // 0x80000000, remainder 0). A zero divisor is replaced by 1 only to keep
    // the datapath X-free; that result is never committed.
    always_comb begin
        w_mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        w_mul_u = {32'd0, a} * {32'd0, b};
        w_sdiv  = (md_op == OP_DIV);
        w_a_abs = (w_sdiv && a[31]) ? (32'd0 - a) : a;
        w_b_abs = (w_sdiv && b[31]) ? (32'd0 - b) : b;
        w_div_b = w_dz ? 32'd1 : w_b_abs;
        w_q_u   = w_a_abs / w_div_b;
        w_r_u   = w_a_abs % w_div_b;
        w_q     = (w_sdiv && (a[31] ^ b[31])) ? (32'd0 - w_q_u) : w_q_u;
        w_r     = (w_sdiv && a[31]) ? (32'd0 - w_r_u) : w_r_u;
        w_res   = 64'd0;
        case (md_op)
            OP_MULT:  w_res = w_mul_s;
            OP_MULTU: w_res = w_mul_u;
            OP_DIV,
            OP_DIVU:  w_res = {w_r, w_q};
            default:  w_res = 64'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: stay in RUN across a back-to-back issue
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_done)   w_next = w_accept ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: busy mirrors the RUN state; stall also covers the issue cycle
    always_comb begin
        busy     = (r_state == S_RUN);
        md_stall = busy || (start && !md_op[2]);
    end

    // Busy countdown: load on accept, step down while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (r_state == S_RUN)
            r_cnt <= r_cnt - CW'(1);
    end

    // Pending result captured at the issue edge; operands are not looked at again
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend    <= 64'd0;
            r_pend_ok <= 1'b0;
        end else if (w_accept) begin
            r_pend    <= w_res;
            r_pend_ok <= !(w_is_div && w_dz);
        end
    end

    // HI/LO: commit pending on the final busy edge, mthi/mtlo only when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            if (r_pend_ok) begin
                r_hi <= r_pend[63:32];
                r_lo <= r_pend[31:0];
            end
        end else if (w_idle_start && (md_op == OP_MTHI)) begin
            r_hi <= a;
        end else if (w_idle_start && (md_op == OP_MTLO)) begin
            r_lo <= a;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the execute stage of the five-stage MIPS pipeline. It takes the forwarded operands leaving the E-stage pipeline register, runs multi-cycle mult/multu/div/divu operations and single-cycle mthi/mtlo writes, and holds the architectural HI/LO registers. HI/LO feed the E-stage result mux (mfhi/mflo), and that result travels into the M-stage register. `busy` and `md_stall` tell the hazard unit to freeze the D-stage register and clear the E-stage register while an md-class instruction is waiting in D.

## Interface
- `MULT_CYCLES`, default 5: busy duration of mult/multu, in cycles, legal range ≥1.
- `DIV_CYCLES`, default 10: busy duration of div/divu, in cycles, legal range ≥1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `start`  in  1  one-cycle request qualifying `md_op`; driven by the E-stage decode.
- `md_op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
- `a`  in  32  rs operand (forwarded V1 in E stage).
- `b`  in  32  rt operand (forwarded V2 in E stage).
- `busy`  out  1  registered; high while a mult/div is in progress.
- `md_stall`  out  1  combinational; equals `busy` OR (`start` AND `md_op` is 0–3).
- `hi`  out  32  registered HI.
- `lo`  out  32  registered LO.

## Operation
- States: IDLE, RUN. There is a down-counter `cnt` (4+ bits, sized for the larger parameter) and a 64-bit pending-result register.
- In IDLE with `start`=1:
  - op 0–3: latch the full 64-bit result into pending and load `cnt` with MULT_CYCLES or DIV_CYCLES. Go to RUN and set `busy`=1.
  - op 4: `hi`←`a` at this edge.
  - op 5: `lo`←`a` at this edge.
  - op 6–7: no effect.
- In RUN: decrement `cnt` each edge. On the edge where `cnt` goes 1→0, commit pending to `{hi,lo}`, clear `busy`, and return to IDLE.
- `start` while in RUN, any op, is ignored. The hazard unit guarantees it never happens; the bench checks that it is ignored.
- Arithmetic for MULT and MULTU:
  - MULT: `{hi,lo}` = signed(a)×signed(b), full 64 bits.
  - MULTU: `{hi,lo}` = unsigned 64-bit product.
- Arithmetic for DIV and DIVU:
  - DIV: `lo` = quotient truncated toward zero; `hi` = remainder, whose sign follows the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
  - Divide by zero (b=0, DIV or DIVU) still runs DIV_CYCLES with `busy` high, then leaves `hi`/`lo` unchanged.
- Operands are sampled only at the start edge. Later changes on `a`/`b` have no effect on a running operation.

## Timing
- Reset (`reset`=0, asynchronous) sets `hi`=0, `lo`=0, `busy`=0, `cnt`=0 and the state to IDLE. Reset mid-operation aborts it: nothing is committed and HI/LO read 0.
- Start accepted at edge E0: `busy`=1 from E0 until edge E0+N, where N = MULT_CYCLES or DIV_CYCLES. `busy` is high for exactly N cycles.
- At edge E0+N, new `hi`/`lo` become visible in the same cycle that `busy` falls.
- A new start is accepted at edge E0+N, back-to-back with no idle cycle.
- MTHI/MTLO latency is 1 edge. `busy` stays 0 for these ops.
- `md_stall` rises combinationally in the start cycle and stays high until `busy` falls.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then release -> `hi`=`lo`=0, `busy`=0; MTHI with a=0x12345678 -> `hi`=0x12345678 after 1 edge, `lo` still 0.
- MULT, a=0xFFFFFFFE (-2), b=0x00000003 -> `busy` high exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU, a=7, b=2 -> `lo`=3, `hi`=1. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Divide by zero with prior hi=0xAAAA0000, lo=0x0000BBBB -> `busy` high 10 cycles, then `hi`/`lo` unchanged.
- Start of MTLO or MULT during RUN, and changes on `a`/`b` mid-operation -> ignored; the result matches the original operands and `busy` length is unchanged. Back-to-back MULT issued at the edge where `busy` falls -> accepted, `busy` stays high 5 more cycles.
- `reset`=0 asserted in the 3rd busy cycle of a DIV -> `busy`, `hi`, `lo` go to 0 immediately, with no later commit.
